// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, quadrant codes and helpers for the CORDIC sin/cos pipeline
package cordic_pkg;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quad_t;

  // CORDIC gain 0.6072529 in unsigned Q0.32
  localparam logic [31:0] CORDIC_GAIN = 32'd2608131346;

  // atan(2^-i) as a fraction of one turn, scaled by 2^32
  function automatic logic [31:0] atan32(input int i);
    case (i)
      0:  atan32 = 32'h2000_0000;
      1:  atan32 = 32'h12E4_051E;
      2:  atan32 = 32'h09FB_385B;
      3:  atan32 = 32'h0511_11D4;
      4:  atan32 = 32'h028B_0D43;
      5:  atan32 = 32'h0145_D7E1;
      6:  atan32 = 32'h00A2_F61E;
      7:  atan32 = 32'h0051_7C55;
      8:  atan32 = 32'h0028_BE53;
      9:  atan32 = 32'h0014_5F2F;
      10: atan32 = 32'h000A_2F98;
      11: atan32 = 32'h0005_17CC;
      12: atan32 = 32'h0002_8BE6;
      13: atan32 = 32'h0001_45F3;
      14: atan32 = 32'h0000_A2FA;
      15: atan32 = 32'h0000_517D;
      16: atan32 = 32'h0000_28BE;
      17: atan32 = 32'h0000_145F;
      18: atan32 = 32'h0000_0A30;
      19: atan32 = 32'h0000_0518;
      20: atan32 = 32'h0000_028C;
      21: atan32 = 32'h0000_0146;
      22: atan32 = 32'h0000_00A3;
      23: atan32 = 32'h0000_0051;
      default: atan32 = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] atan_zw(input int i, input int zw);
    atan_zw = atan32(i) >> (32 - zw);
  endfunction

  function automatic logic [31:0] kscale(input int ow, input int guard);
    logic [63:0] p;
    p = 64'(CORDIC_GAIN) * 64'((1 << (ow - 1)) - 1);
    p = (p << guard) + 64'h0000_0000_8000_0000;
    kscale = p[63:32];
  endfunction

endpackage

// File: rtl/cordic_sincos_pipe_if.sv
// rtl/cordic_sincos_pipe_if.sv - phase-in / sin-cos-out handshake bundle
interface cordic_sincos_pipe_if #(
  parameter int PW = 16,
  parameter int OW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PW-1:0]        in_phase;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_sin;
  logic signed [OW-1:0] out_cos;

  modport master (
    output in_valid, in_phase, out_ready,
    input  in_ready, out_valid, out_sin, out_cos
  );

  modport slave (
    input  in_valid, in_phase, out_ready,
    output in_ready, out_valid, out_sin, out_cos
  );
endinterface

// File: rtl/cordic_rot_stage.sv
// rtl/cordic_rot_stage.sv - one CORDIC micro-rotation register stage
module cordic_rot_stage
  import cordic_pkg::*;
#(
  parameter int             IW       = 14,
  parameter int             ZW       = 16,
  parameter int             SHIFT    = 0,
  parameter logic [ZW-1:0]  ATAN_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 prev_valid,
  input  logic signed [IW-1:0] prev_x,
  input  logic signed [IW-1:0] prev_y,
  input  logic signed [ZW-1:0] prev_z,
  input  quad_t                prev_q,
  output logic                 valid,
  output logic signed [IW-1:0] x,
  output logic signed [IW-1:0] y,
  output logic signed [ZW-1:0] z,
  output quad_t                q
);
  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;

  assign xs = prev_x >>> SHIFT;
  assign ys = prev_y >>> SHIFT;

  // negative residual angle rotates backward
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      q     <= prev_q;
      if (prev_z[ZW-1]) begin
        x <= prev_x + ys;
        y <= prev_y - xs;
        z <= prev_z + $signed(ATAN_VAL);
      end else begin
        x <= prev_x - ys;
        y <= prev_y + xs;
        z <= prev_z - $signed(ATAN_VAL);
      end
    end
  end
endmodule

// File: rtl/cordic_sincos_pipe.sv
// rtl/cordic_sincos_pipe.sv - fully pipelined CORDIC sin/cos generator with global stall
module cordic_sincos_pipe
  import cordic_pkg::*;
#(
  parameter int PW    = 16,
  parameter int OW    = 8,
  parameter int NITER = 12,
  parameter int GUARD = 4
) (
  input logic                  clk,
  input logic                  rst,
  cordic_sincos_pipe_if.slave  bus
);
  localparam int IW = OW + GUARD + 2;
  localparam int ZW = PW;
  localparam int SW = IW - GUARD + 1;
  localparam logic signed [IW-1:0] KSCALE = IW'(kscale(OW, GUARD));
  localparam logic signed [SW-1:0] OMAX   = SW'((1 << (OW - 1)) - 1);

  logic                 adv;
  logic                 s0_valid;
  logic signed [ZW-1:0] s0_z;
  quad_t                s0_q;

  logic                 vld [NITER+1];
  logic signed [IW-1:0] xr  [NITER+1];
  logic signed [IW-1:0] yr  [NITER+1];
  logic signed [ZW-1:0] zr  [NITER+1];
  quad_t                qr  [NITER+1];

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // fold to the first quadrant; the quadrant code rides along with the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= bus.in_valid;
      s0_z     <= {2'b00, bus.in_phase[PW-3:0]};
      s0_q     <= quad_t'(bus.in_phase[PW-1:PW-2]);
    end
  end

  assign vld[0] = s0_valid;
  assign xr[0]  = KSCALE;
  assign yr[0]  = '0;
  assign zr[0]  = s0_z;
  assign qr[0]  = s0_q;

  for (genvar i = 0; i < NITER; i++) begin : g_stage
    cordic_rot_stage #(
      .IW       (IW),
      .ZW       (ZW),
      .SHIFT    (i),
      .ATAN_VAL (ZW'(atan_zw(i, ZW)))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_valid (vld[i]),
      .prev_x     (xr[i]),
      .prev_y     (yr[i]),
      .prev_z     (zr[i]),
      .prev_q     (qr[i]),
      .valid      (vld[i+1]),
      .x          (xr[i+1]),
      .y          (yr[i+1]),
      .z          (zr[i+1]),
      .q          (qr[i+1])
    );
  end

  function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > OMAX)       sat = OW'(OMAX);
    else if (v < -OMAX) sat = OW'(-OMAX);
    else                sat = OW'(v);
  endfunction

  logic signed [IW-1:0] y_rnd, x_rnd;
  logic signed [SW-1:0] s_val, c_val, sin_m, cos_m;

  always_comb begin
    y_rnd = (yr[NITER] + IW'(1 << (GUARD - 1))) >>> GUARD;
    x_rnd = (xr[NITER] + IW'(1 << (GUARD - 1))) >>> GUARD;
    s_val = SW'(y_rnd);
    c_val = SW'(x_rnd);
    sin_m = s_val;
    cos_m = c_val;
    case (qr[NITER])
      Q0: begin sin_m = s_val;  cos_m = c_val;  end
      Q1: begin sin_m = c_val;  cos_m = -s_val; end
      Q2: begin sin_m = -s_val; cos_m = -c_val; end
      default: begin sin_m = -c_val; cos_m = s_val; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sin   <= '0;
      bus.out_cos   <= '0;
    end else if (adv) begin
      bus.out_valid <= vld[NITER];
      if (vld[NITER]) begin
        bus.out_sin <= sat(sin_m);
        bus.out_cos <= sat(cos_m);
      end
    end
  end
endmodule
